// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - LSU access-type codes, FSM states and alignment helper
package load_store_unit_pkg;

  localparam logic [1:0] STORE_SB  = 2'd0;
  localparam logic [1:0] STORE_SH  = 2'd1;
  localparam logic [1:0] STORE_SW  = 2'd2;
  localparam logic [1:0] STORE_DEF = 2'd3;

  localparam logic [2:0] LOAD_LB  = 3'd0;
  localparam logic [2:0] LOAD_HD  = 3'd1;
  localparam logic [2:0] LOAD_LW  = 3'd2;
  localparam logic [2:0] LOAD_LBU = 3'd3;
  localparam logic [2:0] LOAD_LHU = 3'd4;
  localparam logic [2:0] LOAD_DEF = 3'd7;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  // LOAD_DEF fetches the whole word, so it carries no alignment requirement.
  function automatic logic is_misaligned(input logic is_store, input logic [1:0] st_type,
                                         input logic [2:0] ld_type, input logic [1:0] off);
    if (is_store)
      return ((st_type == STORE_SH) && off[0]) || ((st_type == STORE_SW) && (off != 2'b00));
    return (((ld_type == LOAD_HD) || (ld_type == LOAD_LHU)) && off[0]) ||
           ((ld_type == LOAD_LW) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - extracts and extends a byte/half/word from a read word
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  load_type,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    shifted = rdata >> {byte_off, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = byte_off[1] ? rdata[31:16] : rdata[15:0];
    case (load_type)
      LOAD_LB:  result = {{24{byte_v[7]}}, byte_v};
      LOAD_LBU: result = {24'h0, byte_v};
      LOAD_HD:  result = {{16{half_v[15]}}, half_v};
      LOAD_LHU: result = {16'h0, half_v};
      default:  result = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage data-port engine with req/gnt/rvalid bus, stall and timeout
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            mem_write,
  input  logic [1:0]      mem_store_type,
  input  logic            wb_load,
  input  logic [2:0]      mem_load_type,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            lsu_stall,
  output logic            lsu_done,
  output logic [XLEN-1:0] load_data,
  output logic            misalign,
  output logic            bus_err,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);

  lsu_state_e  state, state_n;
  logic [31:0] cnt;
  logic        misalign_q, bus_err_q;
  logic [2:0]  ld_type_q;
  logic [1:0]  off_q;
  logic [31:0] ld_result;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic        is_store, access, mis, timeout_hit;

  assign is_store    = mem_write && (mem_store_type != STORE_DEF);
  assign access      = ex_valid && (is_store || wb_load);
  assign mis         = is_misaligned(is_store, mem_store_type, mem_load_type, addr[1:0]);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TIMEOUT_CYCLES - 1);

  always_comb begin
    st_wdata = store_data;
    st_be    = 4'b1111;
    case (mem_store_type)
      STORE_SB: begin
        st_wdata = {4{store_data[7:0]}};
        st_be    = 4'b0001 << addr[1:0];
      end
      STORE_SH: begin
        st_wdata = {2{store_data[15:0]}};
        st_be    = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n   = state;
    lsu_stall = 1'b0;
    case (state)
      LSU_IDLE: if (access) begin
        lsu_stall = 1'b1;
        state_n   = mis ? LSU_DONE : LSU_REQ;
      end
      LSU_REQ: begin
        lsu_stall = 1'b1;
        if (dmem_gnt)         state_n = dmem_we ? LSU_DONE : LSU_WAIT;
        else if (timeout_hit) state_n = LSU_DONE;
      end
      LSU_WAIT: begin
        lsu_stall = 1'b1;
        if (dmem_rvalid || timeout_hit) state_n = LSU_DONE;
      end
      default: state_n = LSU_IDLE;
    endcase
  end

  // Bus fields are captured at accept so they stay stable for the whole REQ phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LSU_IDLE;
      cnt        <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      ld_type_q  <= LOAD_DEF;
      off_q      <= 2'b00;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= 4'b0000;
      load_data  <= '0;
    end else begin
      state <= state_n;
      case (state)
        LSU_IDLE: if (access) begin
          misalign_q <= mis;
          bus_err_q  <= 1'b0;
          cnt        <= '0;
          if (!mis) begin
            dmem_we    <= is_store;
            dmem_addr  <= {addr[31:2], 2'b00};
            dmem_wdata <= is_store ? st_wdata : '0;
            dmem_be    <= is_store ? st_be : 4'b1111;
            ld_type_q  <= mem_load_type;
            off_q      <= addr[1:0];
          end
        end
        LSU_REQ: begin
          cnt <= cnt + 32'd1;
          if (!dmem_gnt && timeout_hit) bus_err_q <= 1'b1;
        end
        LSU_WAIT: begin
          cnt <= cnt + 32'd1;
          if (dmem_rvalid)      load_data <= ld_result;
          else if (timeout_hit) bus_err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dmem_req = (state == LSU_REQ);
  assign lsu_done = (state == LSU_DONE);
  assign misalign = lsu_done && misalign_q;
  assign bus_err  = lsu_done && bus_err_q;

  lsu_load_align u_load_align (
    .rdata     (dmem_rdata),
    .byte_off  (off_q),
    .load_type (ld_type_q),
    .result    (ld_result)
  );

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed scoreboard bench for load_store_unit
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk, rst, ex_valid, mem_write, wb_load;
  logic [1:0]  mem_store_type;
  logic [2:0]  mem_load_type;
  logic [31:0] addr, store_data, load_data, dmem_addr, dmem_wdata, dmem_rdata;
  logic        lsu_stall, lsu_done, misalign, bus_err, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [3:0]  dmem_be;

  typedef struct {
    logic        mis;
    logic        berr;
    logic        chk_ld;
    logic [31:0] ld;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int cyc, reqc;

  load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_write(mem_write),
    .mem_store_type(mem_store_type), .wb_load(wb_load), .mem_load_type(mem_load_type),
    .addr(addr), .store_data(store_data), .lsu_stall(lsu_stall), .lsu_done(lsu_done),
    .load_data(load_data), .misalign(misalign), .bus_err(bus_err), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic mis, input logic berr, input logic chk_ld, input logic [31:0] ld);
    exp_t e;
    e.mis = mis; e.berr = berr; e.chk_ld = chk_ld; e.ld = ld;
    sb.push_back(e);
  endtask

  task automatic issue(input logic st, input logic [1:0] stt, input logic ld, input logic [2:0] ldt,
                       input logic [31:0] a, input logic [31:0] d);
    ex_valid = 1'b1; mem_write = st; mem_store_type = stt;
    wb_load = ld; mem_load_type = ldt; addr = a; store_data = d;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; mem_write = 1'b0; wb_load = 1'b0;
    mem_store_type = STORE_DEF; mem_load_type = LOAD_DEF;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    exp_t e;
    cycles = 0;
    while (lsu_done !== 1'b1 && cycles < budget) begin
      tick();
      cycles++;
    end
    chk({tag, "_done"}, 32'(lsu_done), 32'd1);
    chk({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_misalign"}, 32'(misalign), 32'(e.mis));
      chk({tag, "_bus_err"}, 32'(bus_err), 32'(e.berr));
      if (e.chk_ld) chk({tag, "_load_data"}, load_data, e.ld);
    end
  endtask

  task automatic do_store(input string tag, input logic [1:0] stt, input logic also_load,
                          input logic [31:0] a, input logic [31:0] d, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input int gnt_delay);
    int c;
    push(1'b0, 1'b0, 1'b0, 32'h0);
    issue(1'b1, stt, also_load, LOAD_LW, a, d);
    #1 chk({tag, "_stall_t0"}, 32'(lsu_stall), 32'd1);
    tick();
    idle_inputs();
    for (int i = 0; i <= gnt_delay; i++) begin
      chk({tag, "_req"}, 32'(dmem_req), 32'd1);
      chk({tag, "_we"}, 32'(dmem_we), 32'd1);
      chk({tag, "_be"}, 32'(dmem_be), 32'(exp_be));
      chk({tag, "_wdata"}, dmem_wdata, exp_wd);
      chk({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
      if (i == gnt_delay) dmem_gnt = 1'b1;
      tick();
    end
    dmem_gnt = 1'b0;
    chk({tag, "_stall_done"}, 32'(lsu_stall), 32'd0);
    wait_done(tag, 0, c);
    tick();
  endtask

  task automatic do_load(input string tag, input logic [2:0] ldt, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] exp_ld);
    int c;
    push(1'b0, 1'b0, 1'b1, exp_ld);
    issue(1'b0, STORE_DEF, 1'b1, ldt, a, 32'hFFFF_FFFF);
    tick();
    idle_inputs();
    chk({tag, "_req"}, 32'(dmem_req), 32'd1);
    chk({tag, "_we"}, 32'(dmem_we), 32'd0);
    chk({tag, "_be"}, 32'(dmem_be), 32'hF);
    chk({tag, "_wdata"}, dmem_wdata, 32'h0);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = ~rd;
    tick();
    dmem_gnt = 1'b0; dmem_rdata = rd;
    chk({tag, "_wait_req"}, 32'(dmem_req), 32'd0);
    chk({tag, "_wait_stall"}, 32'(lsu_stall), 32'd1);
    tick();
    dmem_rvalid = 1'b0;
    wait_done(tag, 0, c);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    addr = 32'h0; store_data = 32'h0;
    idle_inputs();
    tick(); tick();
    chk("rst_stall", 32'(lsu_stall), 32'd0);
    chk("rst_done", 32'(lsu_done), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    rst = 1'b0;
    tick();

    do_store("sw", STORE_SW, 1'b0, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 0);
    do_store("sb", STORE_SB, 1'b0, 32'h103, 32'h000000A5, 4'b1000, 32'hA5A5A5A5, 0);
    do_store("sh_slow", STORE_SH, 1'b0, 32'h102, 32'h1234BEEF, 4'b1100, 32'hBEEFBEEF, 2);
    do_store("st_wins", STORE_SW, 1'b1, 32'h104, 32'h0BADF00D, 4'b1111, 32'h0BADF00D, 0);

    issue(1'b1, STORE_DEF, 1'b0, LOAD_DEF, 32'h108, 32'h1);
    #1 chk("sdef_stall", 32'(lsu_stall), 32'd0);
    tick();
    idle_inputs();
    chk("sdef_req", 32'(dmem_req), 32'd0);
    chk("sdef_done", 32'(lsu_done), 32'd0);

    do_load("lb", LOAD_LB, 32'h102, 32'h12F0_3456, 32'hFFFF_FFF0);
    do_load("lb_pos", LOAD_LB, 32'h100, 32'h12F0_3456, 32'h0000_0056);
    do_load("lw", LOAD_LW, 32'h104, 32'h8765_4321, 32'h8765_4321);
    do_load("lbu", LOAD_LBU, 32'h102, 32'h12F0_3456, 32'h0000_00F0);

    push(1'b1, 1'b0, 1'b1, 32'h0000_00F0);
    issue(1'b0, STORE_DEF, 1'b1, LOAD_HD, 32'h101, 32'h0);
    #1 chk("lh_mis_stall", 32'(lsu_stall), 32'd1);
    tick();
    idle_inputs();
    chk("lh_mis_req", 32'(dmem_req), 32'd0);
    wait_done("lh_mis", 0, cyc);
    tick();

    push(1'b0, 1'b1, 1'b1, 32'h0000_00F0);
    issue(1'b0, STORE_DEF, 1'b1, LOAD_LW, 32'h200, 32'h0);
    tick();
    idle_inputs();
    reqc = 0;
    cyc = 0;
    while (lsu_done !== 1'b1 && cyc < 300) begin
      if (dmem_req) reqc++;
      tick();
      cyc++;
    end
    chk("to_req_cycles", 32'(reqc), 32'd255);
    wait_done("lw_to", 0, cyc);
    chk("to_req_dropped", 32'(dmem_req), 32'd0);
    tick();
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_0123;
    for (int i = 0; i < 3; i++) begin
      chk("late_done", 32'(lsu_done), 32'd0);
      chk("late_req", 32'(dmem_req), 32'd0);
      tick();
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    chk("late_load_held", load_data, 32'h0000_00F0);

    issue(1'b0, STORE_DEF, 1'b1, LOAD_LHU, 32'h202, 32'h0);
    tick();
    idle_inputs();
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk("rst_wait_stall_pre", 32'(lsu_stall), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_stall", 32'(lsu_stall), 32'd0);
    chk("rst_async_req", 32'(dmem_req), 32'd0);
    chk("rst_async_load", load_data, 32'd0);
    rst = 1'b0;
    tick();

    do_load("lhu", LOAD_LHU, 32'h202, 32'h8001_0000, 32'h0000_8001);
    do_load("lh", LOAD_HD, 32'h202, 32'h8001_0000, 32'hFFFF_8001);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
